// File: rtl/dec16_timer.sv
// dec16_timer: loadable 16-bit countdown timer built on a ripple-borrow decrementer.
// Optional feature macro: DEC16_TIMER_RELOAD_EN (auto-reload of the count on expiry).
module dec16_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             start,
  input  logic             en,
  input  logic             dec,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             borrow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic             busy_q;
  logic             done_q;
  logic             borrow_q;

  // Decrementer: chain of full subtractors computing q_q - 1.
  logic [WIDTH-1:0] dec_d;
  logic [WIDTH:0]   dec_borrow;

  assign dec_borrow[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sub
    localparam logic SUB_BIT = (i == 0);
    assign dec_d[i]        = q_q[i] ^ SUB_BIT ^ dec_borrow[i];
    assign dec_borrow[i+1] = (~q_q[i] & (SUB_BIT | dec_borrow[i])) | (SUB_BIT & dec_borrow[i]);
  end

  // Final borrow-out is set only when the count was zero (0 -> all ones wrap).
  logic dec_wrap;
  assign dec_wrap = dec_borrow[WIDTH];

  // Count of 0 or 1 means the next enabled RUN cycle expires.
  logic run_expire;
  assign run_expire = (q_q[WIDTH-1:1] == '0);

`ifdef DEC16_TIMER_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
`ifdef DEC16_TIMER_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      // NOTE: pulse outputs default low each cycle with non-blocking assignments,
      // so a later assignment in this block overrides and nothing is held.
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      if (load) begin
        q_q     <= D;
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
`ifdef DEC16_TIMER_RELOAD_EN
        reload_q <= D;
`endif
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (q_q == '0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
              end
            end else if (dec) begin
              q_q      <= dec_d;
              borrow_q <= dec_wrap;
            end
          end
          ST_RUN: begin
            if (en) begin
              if (run_expire) begin
`ifdef DEC16_TIMER_RELOAD_EN
                if (reload_q != '0) begin
                  q_q    <= reload_q;
                  done_q <= 1'b1;
                end else begin
                  q_q     <= '0;
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
`else
                q_q     <= '0;
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
`endif
              end else begin
                q_q <= dec_d;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Q      = q_q;
  assign zero   = (q_q == '0);
  assign busy   = busy_q;
  assign done   = done_q;
  assign borrow = borrow_q;

endmodule
